// File: rtl/gray_bin_conv_pipe.sv
// Pipelined Gray<->binary converter with valid/ready handshake.
// Mode-0 beats are also checked for single-bit steps against the last mode-0 code.
module gray_bin_conv_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             step_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_err
);

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]  s_dat [STAGES];
  logic [STAGES-1:0] s_vld;
  logic [STAGES-1:0] s_mode;
  logic [STAGES-1:0] s_err;

  logic             stall;
  logic             acc;
  logic [WIDTH-1:0] conv;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] diff;
  logic             have_prev;
  logic             step_bad;
  logic             err_in;

  assign stall    = s_vld[STAGES-1] && !out_ready;
  assign in_ready = !stall;
  assign acc      = in_valid && in_ready;

  always_comb begin
    conv = '0;
    if (in_mode) begin
      conv = in_data ^ (in_data >> 1);
    end else begin
      conv[WIDTH-1] = in_data[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--)
        conv[i] = conv[i+1] ^ in_data[i];
    end
  end

  // exactly one differing bit <=> nonzero power of two
  assign diff     = prev ^ in_data;
  assign step_bad = (diff == '0) || ((diff & (diff - ONE)) != '0);
  assign err_in   = !in_mode && have_prev && step_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_vld  <= '0;
      s_mode <= '0;
      s_err  <= '0;
      for (int i = 0; i < STAGES; i++)
        s_dat[i] <= '0;
    end else if (!stall) begin
      s_vld[0]  <= acc;
      s_mode[0] <= acc && in_mode;
      s_err[0]  <= acc && err_in;
      s_dat[0]  <= acc ? conv : '0;
      for (int i = 1; i < STAGES; i++) begin
        s_vld[i]  <= s_vld[i-1];
        s_mode[i] <= s_mode[i-1];
        s_err[i]  <= s_err[i-1];
        s_dat[i]  <= s_dat[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      have_prev <= 1'b0;
      err_count <= '0;
    end else begin
      if (clr_err)
        err_count <= '0;
      else if (acc && err_in && !(&err_count))
        err_count <= err_count + C_ONE;
      // an accepted mode-0 beat re-seeds history even under clr_err
      if (acc && !in_mode) begin
        prev      <= in_data;
        have_prev <= 1'b1;
      end else if (clr_err) begin
        have_prev <= 1'b0;
      end
    end
  end

  assign out_valid = s_vld[STAGES-1];
  assign out_data  = s_dat[STAGES-1];
  assign out_mode  = s_mode[STAGES-1];
  assign step_err  = s_err[STAGES-1];

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Bench for gray_bin_conv_pipe: directed phases plus random traffic.
// A second instance with a 2-bit counter covers saturation.
`timescale 1ns/1ps
module tb_gray_bin_conv_pipe;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic [W-1:0] in_data = '0;
  logic         in_mode = 0;
  logic         out_ready = 1;
  logic         clr_err = 0;

  logic         in_ready, out_valid, out_mode, step_err;
  logic [W-1:0] out_data;
  logic [15:0]  err_count;

  logic         s_in_ready, s_out_valid, s_out_mode, s_step_err;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_err_count;

  gray_bin_conv_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode),
    .step_err(step_err), .err_count(err_count),
    .clr_err(clr_err)
  );

  gray_bin_conv_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_mode(s_out_mode),
    .step_err(s_step_err), .err_count(s_err_count),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [W-1:0] m_prev = '0;
  bit           m_have = 0;
  int           m_cnt  = 0;
  int           m_cnt2 = 0;
  bit           rnd_rdy = 0;

  logic [W-1:0] q_d[$];
  bit           q_m[$];
  bit           q_e[$];
  int           q_c[$];
  bit           q_t[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b = '0;
    for (int i = 0; i < W; i++) b = b ^ (g >> i);
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_accept(input bit m, input logic [W-1:0] d,
                              input bit clr, input bit timed);
    bit e;
    e = !m && m_have && ($countones(m_prev ^ d) != 1);
    q_d.push_back(m ? b2g(d) : g2b(d));
    q_m.push_back(m);
    q_e.push_back(e);
    q_c.push_back(cyc);
    q_t.push_back(timed);
    if (clr) begin
      m_cnt  = 0;
      m_cnt2 = 0;
    end else if (e) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (!m) begin
      m_prev = d;
      m_have = 1;
    end else if (clr) begin
      m_have = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q_d.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        logic [W-1:0] ed;
        bit em, ee, et;
        int ec;
        ed = q_d.pop_front();
        em = q_m.pop_front();
        ee = q_e.pop_front();
        ec = q_c.pop_front();
        et = q_t.pop_front();
        chk("out_data", int'(out_data), int'(ed));
        chk("out_mode", int'(out_mode), int'(em));
        chk("step_err", int'(step_err), int'(ee));
        chk("sat_data", int'(s_out_data), int'(ed));
        if (et) chk("latency", cyc - ec, S);
      end
    end
  end

  task automatic send(input bit m, input logic [W-1:0] d,
                      input bit clr, input bit timed);
    bit ok = 0;
    in_valid = 1;
    in_mode  = m;
    in_data  = d;
    clr_err  = clr;
    for (int k = 0; k < 60 && !ok; k++) begin
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        model_accept(m, d, clr, timed);
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 0;
    clr_err  = 0;
  endtask

  task automatic drain();
    rnd_rdy   = 0;
    out_ready = 1;
    for (int k = 0; k < 60 && q_d.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    if (q_d.size() != 0) chk("drain_timeout", q_d.size(), 0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt"}, int'(err_count), m_cnt);
    chk({tag, "_cnt2"}, int'(s_err_count), m_cnt2);
  endtask

  initial begin
    logic [W-1:0] snap_d;
    bit snap_m, snap_e;

    // reset state
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_mode", int'(out_mode), 0);
    chk("rst_step_err", int'(step_err), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 rst = 0;

    // mode-0 sweep of Gray codes 0..15, back to back
    for (int v = 0; v < 16; v++) send(0, b2g(4'(v)), 0, 1);
    drain();
    chk_counts("sweep");

    // mode-1 beats interleaved with mode-0 (1000 -> 0000 wrap is legal)
    send(1, 4'b0101, 0, 1);
    send(0, 4'b0000, 0, 1);
    send(1, 4'b1111, 0, 1);
    send(1, 4'b0000, 0, 1);
    send(0, 4'b0001, 0, 1);
    drain();
    chk_counts("mode1");

    // step violations: 0000 0001 0011 0000 0000
    send(0, 4'b0000, 0, 1);
    send(0, 4'b0001, 0, 1);
    send(0, 4'b0011, 0, 1);
    send(0, 4'b0000, 0, 1);
    send(0, 4'b0000, 0, 1);
    drain();
    chk_counts("viol2");
    chk("viol2_exact", int'(err_count), 2);
    repeat (3) send(0, 4'b0000, 0, 1);
    drain();
    chk_counts("viol5");
    chk("sat_hold", int'(s_err_count), 3);

    // backpressure for 3 cycles with output valid
    send(0, 4'b0001, 0, 0);
    send(0, 4'b0011, 0, 0);
    send(0, 4'b0010, 0, 0);
    out_ready = 0;
    in_valid  = 1;
    in_mode   = 1;
    in_data   = 4'b0110;
    @(negedge clk);
    snap_d = out_data;
    snap_m = out_mode;
    snap_e = step_err;
    chk("bp_valid", int'(out_valid), 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_data", int'(out_data), int'(snap_d));
      chk("bp_mode", int'(out_mode), int'(snap_m));
      chk("bp_err", int'(step_err), int'(snap_e));
    end
    @(posedge clk);
    #1 out_ready = 1;
    send(1, 4'b0110, 0, 0);
    drain();

    // clr_err together with an erroring beat, then a legal step from it
    send(0, 4'b0010, 1, 1);
    send(0, 4'b0110, 0, 1);
    drain();
    chk_counts("clr");
    chk("clr_exact", int'(err_count), 0);

    // random traffic with random backpressure and idle gaps
    rnd_rdy = 1;
    for (int k = 0; k < 80; k++) begin
      bit m;
      logic [W-1:0] d;
      if ($urandom_range(0, 4) == 0) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
      end
      m = 1'($urandom_range(0, 1));
      if (!m && $urandom_range(0, 2) != 0)
        d = m_prev ^ (4'b0001 << $urandom_range(0, 3));
      else
        d = 4'($urandom);
      send(m, d, 0, 0);
    end
    drain();
    chk_counts("random");

    // reset with two beats in flight
    send(0, 4'b0110, 0, 1);
    send(0, 4'b0110, 0, 1);
    rst = 1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_cnt", int'(err_count), 0);
    chk("mid_rst_cnt2", int'(s_err_count), 0);
    q_d.delete(); q_m.delete(); q_e.delete(); q_c.delete(); q_t.delete();
    m_have = 0; m_prev = '0; m_cnt = 0; m_cnt2 = 0;
    @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_idle", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    send(0, 4'b1010, 0, 1);
    send(0, 4'b1011, 0, 1);
    drain();
    chk_counts("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
